keypad_entry_ctrl: RTL and testbench

Sequences key events from the 4x4 keypad scanner into multi-digit BCD entries. Detects new presses on the scanner's level `ready`, samples the registered key code one cycle later, and edits an entry buffer (append digit, backspace, clear, enter). On enter it hands the finished entry to a downstream consumer over a valid/ready handshake. Sits between the keypad scanner and the application logic and display.

---
 rtl/keypad_entry_ctrl.sv | 177 +++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// Purpose: turns keypad scanner press events into a multi-digit BCD entry
//   (append/backspace/clear/enter) and offers finished entries downstream.
// Latency: press seen at edge k, key_code sampled and applied at edge k+1.
// Backpressure: entry held on entry_valid until entry_ready; presses during
//   that wait are dropped, not queued.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   key_code, key_ready - scanner key code and "key held" level
//   digits, digit_count - live edit buffer (newest digit in [3:0]) and count
//   entry_data/len/valid, entry_ready - completed entry handshake
//   key_err, timeout    - one-cycle pulses: rejected command, idle discard
module keypad_entry_ctrl #(
  parameter int MAX_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int LW             = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              key_code,
  input  logic                    key_ready,
  output logic [4*MAX_DIGITS-1:0] digits,
  output logic [LW-1:0]           digit_count,
  output logic [4*MAX_DIGITS-1:0] entry_data,
  output logic [LW-1:0]           entry_len,
  output logic                    entry_valid,
  input  logic                    entry_ready,
  output logic                    key_err,
  output logic                    timeout
);

  localparam int            DW   = 4 * MAX_DIGITS;
  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] CMAX = LW'(MAX_DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SEND} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_prev_ready;
  logic [DW-1:0] r_digits, w_digits_nxt;
  logic [LW-1:0] r_count, w_count_nxt;
  logic [DW-1:0] r_entry_data, w_entry_data_nxt;
  logic [LW-1:0] r_entry_len, w_entry_len_nxt;
  logic          r_entry_valid, w_entry_valid_nxt;
  logic          r_key_err, w_key_err_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic [CW-1:0] r_tcnt, w_tcnt_nxt;

  logic          w_press;
  logic          w_xfer;

  // prev_ready resets high so a key held through reset needs a release first.
  assign w_press = key_ready & ~r_prev_ready;
  assign w_xfer  = r_entry_valid & entry_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_prev_ready  <= 1'b1;
      r_digits      <= '0;
      r_count       <= '0;
      r_entry_data  <= '0;
      r_entry_len   <= '0;
      r_entry_valid <= 1'b0;
      r_key_err     <= 1'b0;
      r_timeout     <= 1'b0;
      r_tcnt        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_prev_ready  <= key_ready;
      r_digits      <= w_digits_nxt;
      r_count       <= w_count_nxt;
      r_entry_data  <= w_entry_data_nxt;
      r_entry_len   <= w_entry_len_nxt;
      r_entry_valid <= w_entry_valid_nxt;
      r_key_err     <= w_key_err_nxt;
      r_timeout     <= w_timeout_nxt;
      r_tcnt        <= w_tcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_digits_nxt      = r_digits;
    w_count_nxt       = r_count;
    w_entry_data_nxt  = r_entry_data;
    w_entry_len_nxt   = r_entry_len;
    w_entry_valid_nxt = r_entry_valid;
    w_key_err_nxt     = 1'b0;
    w_timeout_nxt     = 1'b0;
    w_tcnt_nxt        = r_tcnt;

    // Data and length stay put after a transfer; only valid drops.
    if (w_xfer) begin
      w_entry_valid_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        // A press on the expiry cycle wins: counter clears, no timeout.
        if (w_press) begin
          w_state_nxt = S_CAPTURE;
          w_tcnt_nxt  = '0;
        end else if (r_count == '0) begin
          w_tcnt_nxt = '0;
        end else if (r_tcnt == TMAX) begin
          w_digits_nxt  = '0;
          w_count_nxt   = '0;
          w_timeout_nxt = 1'b1;
          w_tcnt_nxt    = '0;
        end else begin
          w_tcnt_nxt = r_tcnt + CW'(1);
        end
      end

      S_CAPTURE: begin
        w_state_nxt = S_IDLE;
        w_tcnt_nxt  = '0;
        if (key_code <= 4'h9) begin
          if (r_count < CMAX) begin
            // Shift rather than slice so MAX_DIGITS = 1 stays legal.
            w_digits_nxt = (r_digits << 4) | DW'(key_code);
            w_count_nxt  = r_count + LW'(1);
          end else begin
            w_key_err_nxt = 1'b1;
          end
        end else begin
          case (key_code)
            4'hA: begin
              if (r_count != '0) begin
                w_entry_data_nxt  = r_digits;
                w_entry_len_nxt   = r_count;
                w_entry_valid_nxt = 1'b1;
                w_digits_nxt      = '0;
                w_count_nxt       = '0;
                w_state_nxt       = S_SEND;
              end else begin
                w_key_err_nxt = 1'b1;
              end
            end
            4'hB: begin
              if (r_count != '0) begin
                w_digits_nxt = r_digits >> 4;
                w_count_nxt  = r_count - LW'(1);
              end else begin
                w_key_err_nxt = 1'b1;
              end
            end
            4'hC: begin
              w_digits_nxt = '0;
              w_count_nxt  = '0;
            end
            default: ;
          endcase
        end
      end

      S_SEND: begin
        // Idle counter frozen here; presses are simply not acted on.
        if (!r_entry_valid || entry_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign digits      = r_digits;
  assign digit_count = r_count;
  assign entry_data  = r_entry_data;
  assign entry_len   = r_entry_len;
  assign entry_valid = r_entry_valid;
  assign key_err     = r_key_err;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Purpose: self-checking bench for keypad_entry_ctrl (MAX_DIGITS=4, TIMEOUT_CYCLES=20).
// Inputs driven 1 time unit after the rising edge; outputs sampled there or on
// the falling edge. Completed entries are scoreboarded through a queue.
module tb_keypad_entry_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic [15:0] entry_data;
  logic [2:0]  entry_len;
  logic        entry_valid;
  logic        entry_ready;
  logic        key_err;
  logic        timeout;

  keypad_entry_ctrl #(.MAX_DIGITS(4), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_ready(key_ready),
    .digits(digits), .digit_count(digit_count), .entry_data(entry_data),
    .entry_len(entry_len), .entry_valid(entry_valid), .entry_ready(entry_ready),
    .key_err(key_err), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  len;
  } ent_t;

  ent_t exp_q[$];
  ent_t mon_e;

  int n_chk = 0;
  int n_bad = 0;
  int n_err = 0;
  int n_to  = 0;
  int n_vcyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse counters and entry scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_err) n_err++;
      if (timeout) n_to++;
      if (entry_valid) n_vcyc++;
      if (entry_valid && entry_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_entry", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_entry_data", 32'(entry_data), 32'(mon_e.data));
          check("sb_entry_len", 32'(entry_len), 32'(mon_e.len));
        end
      end
    end
  end

  // One key: rise, detect edge, capture edge, then release for one cycle.
  task automatic press(input logic [3:0] k);
    @(posedge clk); #1;
    key_code  = k;
    key_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 key_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic enter(input logic [15:0] d, input logic [2:0] l);
    ent_t e;
    e.data = d;
    e.len  = l;
    exp_q.push_back(e);
    press(4'hA);
  endtask

  int e0, v0, t0;

  initial begin
    rst_n       = 1'b0;
    key_ready   = 1'b1;
    key_code    = 4'h5;
    entry_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_count", 32'(digit_count), 32'h0);
    check("rst_entry_valid", 32'(entry_valid), 32'h0);
    check("rst_entry_data", 32'(entry_data), 32'h0);
    check("rst_entry_len", 32'(entry_len), 32'h0);
    check("rst_pulses", 32'({key_err, timeout}), 32'h0);

    // Key held through reset release: must be ignored until released.
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("held_digits", 32'(digits), 32'h0);
    check("held_count", 32'(digit_count), 32'h0);
    key_ready = 1'b0;
    @(posedge clk); #1;
    press(4'h5);
    check("after_release_digits", 32'(digits), 32'h5);
    press(4'hC);
    check("clear_digits", 32'(digits), 32'h0);

    // Zero-wait consumer: 1, 2, 3, enter.
    entry_ready = 1'b1;
    press(4'h1);
    press(4'h2);
    press(4'h3);
    check("seq_digits", 32'(digits), 32'h0123);
    v0 = n_vcyc;
    enter(16'h0123, 3'd3);
    repeat (2) @(posedge clk); #1;
    check("zw_valid_cycles", 32'(n_vcyc - v0), 32'd1);
    check("zw_entry_data", 32'(entry_data), 32'h0123);
    check("zw_entry_len", 32'(entry_len), 32'd3);
    check("zw_digits", 32'(digits), 32'h0);
    check("zw_count", 32'(digit_count), 32'h0);
    entry_ready = 1'b0;

    // Full buffer then backspace.
    e0 = n_err;
    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
    check("full_err_none", 32'(n_err - e0), 32'd0);
    press(4'h5);
    check("full_digits", 32'(digits), 32'h9876);
    check("full_count", 32'(digit_count), 32'd4);
    check("full_err_one", 32'(n_err - e0), 32'd1);
    press(4'hB);
    press(4'hB);
    check("bksp_digits", 32'(digits), 32'h0098);
    check("bksp_count", 32'(digit_count), 32'd2);
    press(4'hC);
    check("clr_count", 32'(digit_count), 32'd0);

    // Errors on empty buffer, ignored keys.
    e0 = n_err;
    press(4'hB);
    check("empty_b_err", 32'(n_err - e0), 32'd1);
    press(4'hA);
    check("empty_a_err", 32'(n_err - e0), 32'd2);
    check("empty_a_valid", 32'(entry_valid), 32'd0);
    press(4'h1);
    press(4'hD); press(4'hE); press(4'hF);
    check("def_err", 32'(n_err - e0), 32'd2);
    check("def_digits", 32'(digits), 32'h1);
    check("def_count", 32'(digit_count), 32'd1);
    press(4'hC);

    // Backpressure: entry held, press during SEND dropped.
    press(4'h4);
    press(4'h2);
    enter(16'h0042, 3'd2);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(entry_valid), 32'd1);
      check("bp_data", 32'(entry_data), 32'h0042);
      @(posedge clk); #1;
    end
    press(4'h7);
    check("bp_drop_digits", 32'(digits), 32'h0);
    check("bp_drop_count", 32'(digit_count), 32'd0);
    check("bp_still_valid", 32'(entry_valid), 32'd1);
    entry_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_xfer_valid", 32'(entry_valid), 32'd0);
    check("bp_keep_data", 32'(entry_data), 32'h0042);
    check("bp_keep_len", 32'(entry_len), 32'd2);
    entry_ready = 1'b0;

    // Timeout: capture edge is 2 edges before press() returns.
    t0 = n_to;
    press(4'h5);
    repeat (17) @(posedge clk); #1;
    check("to_early", 32'(timeout), 32'd0);
    check("to_early_digits", 32'(digits), 32'h5);
    @(posedge clk); #1;
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_digits", 32'(digits), 32'h0);
    @(posedge clk); #1;
    check("to_width", 32'(n_to - t0), 32'd1);

    // Press detected on the expiry edge wins.
    t0 = n_to;
    press(4'h5);
    repeat (16) @(posedge clk);
    press(4'h3);
    check("to_race_digits", 32'(digits), 32'h0053);
    check("to_race_none", 32'(n_to - t0), 32'd0);
    press(4'hC);

    // Reset mid-SEND drops the pending entry immediately.
    press(4'h9);
    enter(16'h0009, 3'd1);
    check("ms_valid_pre", 32'(entry_valid), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("ms_valid_rst", 32'(entry_valid), 32'd0);
    check("ms_data_rst", 32'(entry_data), 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("ms_valid_after", 32'(entry_valid), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
